// File: rtl/vload_sequencer_if.sv
// Memory read port of the vector load sequencer: address/read request with
// wait-request stall, and a separate read-data-valid return path.
interface vload_sequencer_if #(
  parameter int WIDTH = 32
);
  // Handshake: a request is accepted on a rising edge where d_read=1 and
  // d_wait=0; the master holds d_read and d_address stable while d_wait=1.
  // Read data returns later, qualified only by d_readdatavalid=1.
  logic [WIDTH-1:0] d_address;
  logic             d_read;
  logic             d_wait;
  logic             d_readdatavalid;
  logic [WIDTH-1:0] d_readdata;

  modport master (
    output d_address, d_read,
    input  d_wait, d_readdatavalid, d_readdata
  );

  modport slave (
    input  d_address, d_read,
    output d_wait, d_readdatavalid, d_readdata
  );
endinterface

// File: rtl/vload_sequencer.sv
// Vector load sequencer: issues one read per element, extracts big-endian
// byte/halfword/word lanes and writes each element back. Optional macro
// VLOAD_SEQUENCER_STRIDE_EN selects the latched byte stride as increment.
module vload_sequencer #(
  parameter int WIDTH   = 32,
  parameter int VLWIDTH = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   base_addr,
  input  logic [WIDTH-1:0]   stride,
  input  logic [VLWIDTH-1:0] vl,
  input  logic [1:0]         load_size,
  input  logic               load_sign_ext,
  output logic               busy,
  output logic               done,
  vload_sequencer_if.master  mem,
  output logic               wb_en,
  output logic [VLWIDTH-1:0] wb_index,
  output logic [WIDTH-1:0]   wb_data,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [VLWIDTH-1:0] index;
  logic [VLWIDTH-1:0] vl_q;
  logic [WIDTH-1:0]   addr;
  logic [WIDTH-1:0]   incr;
  logic [1:0]         size_q;
  logic               sign_q;
  logic [1:0]         lsb_q;
  logic               last_elem;

`ifdef VLOAD_SEQUENCER_STRIDE_EN
  logic [WIDTH-1:0]   stride_q;
`else
  logic               unused_stride;
  assign unused_stride = ^stride;
`endif

  // Big-endian lane select: byte offset 0 is the most significant byte.
  function automatic logic [WIDTH-1:0] extract(
    input logic [WIDTH-1:0] w,
    input logic [1:0]       sz,
    input logic [1:0]       lsb,
    input logic             sx
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (lsb)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = lsb[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   extract = {{24{sx & b[7]}}, b};
      2'b01:   extract = {{16{sx & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  always_comb begin
`ifdef VLOAD_SEQUENCER_STRIDE_EN
    incr = stride_q;
`else
    case (size_q)
      2'b00:   incr = WIDTH'(1);
      2'b01:   incr = WIDTH'(2);
      default: incr = WIDTH'(4);
    endcase
`endif
  end

  assign last_elem     = (index == vl_q - VLWIDTH'(1));
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign mem.d_read    = (state == S_REQ);
  assign mem.d_address = addr;
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = (vl != '0) ? S_REQ : S_DONE;
      S_REQ:  if (!mem.d_wait) state_next = S_RESP;
      S_RESP: if (mem.d_readdatavalid) state_next = last_elem ? S_DONE : S_REQ;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index    <= '0;
      vl_q     <= '0;
      addr     <= '0;
      size_q   <= '0;
      sign_q   <= 1'b0;
      lsb_q    <= '0;
      wb_en    <= 1'b0;
      wb_index <= '0;
      wb_data  <= '0;
`ifdef VLOAD_SEQUENCER_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      wb_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && vl != '0) begin
            index  <= '0;
            vl_q   <= vl;
            addr   <= base_addr;
            size_q <= load_size;
            sign_q <= load_sign_ext;
`ifdef VLOAD_SEQUENCER_STRIDE_EN
            stride_q <= stride;
`endif
          end
        end
        S_REQ: begin
          if (!mem.d_wait) lsb_q <= addr[1:0];
        end
        S_RESP: begin
          if (mem.d_readdatavalid) begin
            wb_en    <= 1'b1;
            wb_index <= index;
            wb_data  <= extract(mem.d_readdata, size_q, lsb_q, sign_q);
            // The address stays on the last element once the vector completes.
            if (!last_elem) begin
              index <= index + VLWIDTH'(1);
              addr  <= addr + incr;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vload_sequencer.sv
// Directed bench for vload_sequencer: a vector table applied in a loop with a
// cycle-level memory responder, plus hand-written reset-abort sequences.
module tb_vload_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] stride;
  logic [5:0]  vl;
  logic [1:0]  load_size;
  logic        load_sign_ext;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [5:0]  wb_index;
  logic [31:0] wb_data;
  logic [1:0]  dbg_state;

  vload_sequencer_if #(.WIDTH(32)) mem ();

  vload_sequencer #(.WIDTH(32), .VLWIDTH(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .stride        (stride),
    .vl            (vl),
    .load_size     (load_size),
    .load_sign_ext (load_sign_ext),
    .busy          (busy),
    .done          (done),
    .mem           (mem),
    .wb_en         (wb_en),
    .wb_index      (wb_index),
    .wb_data       (wb_data),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    logic [5:0]  vl;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] rdata;
    int          nwait;
    int          lat;
    bit          restart;
    int          done_cyc;
  } vec_t;

  vec_t        tv [8];
  logic [31:0] exp_addr [8][5];
  logic [31:0] exp_data [8][5];

  int checks = 0;
  int errors = 0;
  bit ab;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act, input int lim);
    checks++;
    errors++;
    $display("FAIL %s: got %0d allowed %0d", name, act, lim);
  endtask

  // Driver + memory responder + scoreboard for one table entry.
  task automatic run_vec(input int i, input bit abort_mid, output bit aborted);
    int cyc, wb_cnt, req_cnt, wait_left, lat_cnt;
    bit got_done;
    cyc = 0; wb_cnt = 0; req_cnt = 0; lat_cnt = 0; got_done = 0;
    wait_left = tv[i].nwait;
    aborted = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = tv[i].base;
    stride = tv[i].stride;
    vl = tv[i].vl;
    load_size = tv[i].size;
    load_sign_ext = tv[i].sign;
    mem.d_readdata = tv[i].rdata;
    mem.d_wait = 1'b0;
    mem.d_readdatavalid = 1'b0;
    while (!got_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (tv[i].restart && (cyc == 2 || cyc == 3)) begin
        start = 1'b1;
        base_addr = 32'hDEAD0000;
        stride = 32'h40;
        vl = 6'd7;
        load_size = 2'b00;
        load_sign_ext = 1'b1;
      end
      check("busy", busy, 1);
      if (wb_en) begin
        if (wb_cnt < int'(tv[i].vl)) begin
          check("wb_index", wb_index, wb_cnt);
          check("wb_data", wb_data, exp_data[i][wb_cnt]);
        end else flag("extra_wb", wb_cnt + 1, tv[i].vl);
        wb_cnt++;
      end
      if (done) begin
        check("done_cycle", cyc, tv[i].done_cyc);
        check("wb_count", wb_cnt, tv[i].vl);
        check("req_count", req_cnt, tv[i].vl);
        got_done = 1;
      end
      mem.d_readdatavalid = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) mem.d_readdatavalid = 1'b1;
      end
      if (abort_mid && req_cnt == 3 && lat_cnt > 0) begin
        aborted = 1;
        return;
      end
      mem.d_wait = 1'b0;
      if (mem.d_read && !got_done) begin
        if (req_cnt < int'(tv[i].vl)) check("d_address", mem.d_address, exp_addr[i][req_cnt]);
        else flag("extra_read", req_cnt + 1, tv[i].vl);
        if (wait_left > 0) begin
          mem.d_wait = 1'b1;
          wait_left--;
        end else begin
          req_cnt++;
          lat_cnt = tv[i].lat;
        end
      end
    end
    if (!got_done) flag("done_timeout", cyc, 300);
    @(negedge clk);
    mem.d_readdatavalid = 1'b0;
    check("busy_after", busy, 0);
    check("done_pulse", done, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    stride = '0;
    vl = '0;
    load_size = '0;
    load_sign_ext = 1'b0;
    mem.d_wait = 1'b0;
    mem.d_readdatavalid = 1'b1;
    mem.d_readdata = 32'h55AA55AA;

    tv[0] = '{base:32'h100, stride:32'd1, vl:6'd4, size:2'b00, sign:1'b1, rdata:32'h807F01FF,
              nwait:0, lat:1, restart:0, done_cyc:9};
    exp_addr[0] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h0};
    exp_data[0] = '{32'hFFFFFF80, 32'h0000007F, 32'h00000001, 32'hFFFFFFFF, 32'h0};
    tv[1] = '{base:32'h202, stride:32'd8, vl:6'd3, size:2'b01, sign:1'b0, rdata:32'h1234ABCD,
              nwait:0, lat:1, restart:0, done_cyc:7};
`ifdef VLOAD_SEQUENCER_STRIDE_EN
    exp_addr[1] = '{32'h202, 32'h20A, 32'h212, 32'h0, 32'h0};
    exp_data[1] = '{32'h0000ABCD, 32'h0000ABCD, 32'h0000ABCD, 32'h0, 32'h0};
`else
    exp_addr[1] = '{32'h202, 32'h204, 32'h206, 32'h0, 32'h0};
    exp_data[1] = '{32'h0000ABCD, 32'h00001234, 32'h0000ABCD, 32'h0, 32'h0};
`endif
    tv[2] = '{base:32'h300, stride:32'd4, vl:6'd3, size:2'b11, sign:1'b0, rdata:32'hCAFEF00D,
              nwait:5, lat:3, restart:0, done_cyc:18};
    exp_addr[2] = '{32'h300, 32'h304, 32'h308, 32'h0, 32'h0};
    exp_data[2] = '{32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0, 32'h0};
    tv[3] = '{base:32'h400, stride:32'd2, vl:6'd2, size:2'b01, sign:1'b1, rdata:32'h80017FFE,
              nwait:0, lat:1, restart:0, done_cyc:5};
    exp_addr[3] = '{32'h400, 32'h402, 32'h0, 32'h0, 32'h0};
    exp_data[3] = '{32'hFFFF8001, 32'h00007FFE, 32'h0, 32'h0, 32'h0};
    tv[4] = '{base:32'h700, stride:32'd4, vl:6'd0, size:2'b10, sign:1'b0, rdata:32'h12345678,
              nwait:0, lat:1, restart:0, done_cyc:1};
    exp_addr[4] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_data[4] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[5] = '{base:32'h502, stride:32'd1, vl:6'd2, size:2'b00, sign:1'b0, rdata:32'h807F01FF,
              nwait:0, lat:1, restart:0, done_cyc:5};
    exp_addr[5] = '{32'h502, 32'h503, 32'h0, 32'h0, 32'h0};
    exp_data[5] = '{32'h00000001, 32'h000000FF, 32'h0, 32'h0, 32'h0};
    tv[6] = '{base:32'hFFFFFFFC, stride:32'd4, vl:6'd2, size:2'b10, sign:1'b0, rdata:32'h11223344,
              nwait:0, lat:1, restart:1, done_cyc:5};
    exp_addr[6] = '{32'hFFFFFFFC, 32'h00000000, 32'h0, 32'h0, 32'h0};
    exp_data[6] = '{32'h11223344, 32'h11223344, 32'h0, 32'h0, 32'h0};
    tv[7] = '{base:32'h600, stride:32'd4, vl:6'd5, size:2'b10, sign:1'b0, rdata:32'h5A5A0001,
              nwait:0, lat:2, restart:0, done_cyc:16};
    exp_addr[7] = '{32'h600, 32'h604, 32'h608, 32'h60C, 32'h610};
    exp_data[7] = '{32'h5A5A0001, 32'h5A5A0001, 32'h5A5A0001, 32'h5A5A0001, 32'h5A5A0001};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    mem.d_readdatavalid = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d_read", mem.d_read, 0);
    check("rst_d_address", mem.d_address, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_index", wb_index, 0);
    check("rst_wb_data", wb_data, 0);

    for (int i = 0; i < 7; i++) run_vec(i, 1'b0, ab);

    // Reset while element 2 of 5 is waiting for data, then late data.
    run_vec(7, 1'b1, ab);
    check("abort_reached", ab, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_d_read", mem.d_read, 0);
    check("mid_rst_d_address", mem.d_address, 0);
    check("mid_rst_wb_en", wb_en, 0);
    check("mid_rst_wb_index", wb_index, 0);
    check("mid_rst_wb_data", wb_data, 0);
    reset = 1'b0;
    mem.d_readdatavalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      mem.d_readdatavalid = 1'b0;
      check("late_wb_en", wb_en, 0);
      check("late_done", done, 0);
      check("late_busy", busy, 0);
    end
    run_vec(0, 1'b0, ab);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
